frame_stream_writer: RTL and testbench

Consumes the 17-bit tagged pixel stream from the pixel queue FIFO: frame-start, row-start and frame-done markers plus RGB565 pixel words. It groups pixels into fixed-length bursts and writes them through a command/data handshake to the framebuffer memory controller at linear row-major addresses. It checks stream framing and reports frame completion and sync errors to the display/control logic.

---
 rtl/frame_stream_writer.sv | 202 ++++++++++++++++++++
 tb/tb_frame_stream_writer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_writer.sv
// Packs the tagged pixel stream into BURST_LEN-word writes at row-major addresses and checks the frame markers.
// Command is raised two cycles after the last pixel of a burst is read; FIFO reads stop while a burst is in flight or the buffer is full.
module frame_stream_writer #(
    parameter int                    FRAME_WIDTH  = 480,
    parameter int                    FRAME_HEIGHT = 272,
    parameter int                    BURST_LEN    = 16,
    parameter int                    ADDR_WIDTH   = 21,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  queue_empty,
    input  logic [16:0]           queue_data,
    output logic                  queue_rd_en,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [15:0]           mem_wr_data,
    output logic                  mem_wr_valid,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic                  sync_error
);

    localparam int IW = $clog2(BURST_LEN);
    localparam int CW = IW + 1;
    localparam int FW = CW + 1;
    localparam int RW = $clog2(FRAME_HEIGHT + 1);
    localparam int XW = $clog2(FRAME_WIDTH + 1);

    localparam logic [16:0] W_FRAME_START = 17'h10000;
    localparam logic [16:0] W_ROW_START   = 17'h10001;
    localparam logic [16:0] W_FRAME_END   = 17'h1FFFF;

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_CMD, S_DATA, S_DONE} state_t;

    state_t          state;
    logic            rd_allow;
    logic            rd_pend;
    logic            hold_vld;
    logic [16:0]     hold_dat;
    logic [CW-1:0]   count;
    logic [CW-1:0]   beat;
    logic            row_started;
    logic            row_err;
    logic [RW-1:0]   row;
    logic [XW-1:0]   col;
    logic [15:0]     burst_buf [BURST_LEN];

    logic            in_rx;
    logic            word_vld;
    logic [16:0]     word;
    logic [FW-1:0]   fill;
    logic            throttle;
    logic            row_ok;
    logic            col_ok;
    logic            px_store;
    logic [ADDR_WIDTH-1:0] burst_addr;

    assign in_rx    = (state == S_IDLE) || (state == S_RECV);
    assign word_vld = rd_pend || hold_vld;
    assign word     = hold_vld ? hold_dat : queue_data;

    // Count the word in flight so a burst never fills with a read still outstanding.
    assign fill     = FW'(count) + FW'(rd_pend) + FW'(hold_vld);
    assign throttle = fill >= FW'(BURST_LEN);

    assign queue_rd_en = rd_allow && !queue_empty &&
                         ((state == S_IDLE) || ((state == S_RECV) && !throttle));

    assign row_ok   = row_started && (row < RW'(FRAME_HEIGHT));
    assign col_ok   = col < XW'(FRAME_WIDTH);
    assign px_store = (state == S_RECV) && word_vld && !word[16] && row_ok && col_ok;

    // Evaluated with the pre-increment column, so the last pixel sits at start + BURST_LEN - 1.
    assign burst_addr = BASE_ADDR + ADDR_WIDTH'(row) * ADDR_WIDTH'(FRAME_WIDTH)
                      + ADDR_WIDTH'(col) - ADDR_WIDTH'(BURST_LEN - 1);

    always_ff @(posedge clk) begin
        if (px_store)
            burst_buf[count[IW-1:0]] <= word[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            rd_allow      <= 1'b0;
            rd_pend       <= 1'b0;
            hold_vld      <= 1'b0;
            hold_dat      <= '0;
            count         <= '0;
            beat          <= '0;
            row_started   <= 1'b0;
            row_err       <= 1'b0;
            row           <= '0;
            col           <= '0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_wr_data   <= '0;
            mem_wr_valid  <= 1'b0;
            frame_active  <= 1'b0;
            frame_done    <= 1'b0;
            sync_error    <= 1'b0;
        end else begin
            rd_allow   <= 1'b1;
            rd_pend    <= queue_rd_en;
            frame_done <= 1'b0;
            sync_error <= 1'b0;

            // A word landing outside IDLE/RECV is parked and parsed on return.
            if (rd_pend && !in_rx) begin
                hold_vld <= 1'b1;
                hold_dat <= queue_data;
            end else if (in_rx) begin
                hold_vld <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (word_vld && (word == W_FRAME_START)) begin
                        state        <= S_RECV;
                        frame_active <= 1'b1;
                        row_started  <= 1'b0;
                        row_err      <= 1'b0;
                        col          <= '0;
                        count        <= '0;
                    end
                end
                S_RECV: begin
                    if (word_vld) begin
                        if (word == W_FRAME_START) begin
                            sync_error  <= 1'b1;
                            row_started <= 1'b0;
                            row_err     <= 1'b0;
                            col         <= '0;
                            count       <= '0;
                        end else if (word == W_ROW_START) begin
                            if ((col != '0) && (col != XW'(FRAME_WIDTH)))
                                sync_error <= 1'b1;
                            if (!row_started) begin
                                row_started <= 1'b1;
                                row         <= '0;
                            end else if (row < RW'(FRAME_HEIGHT)) begin
                                row <= row + 1'b1;
                            end
                            row_err <= 1'b0;
                            col     <= '0;
                            count   <= '0;
                        end else if (word == W_FRAME_END) begin
                            if (!(row_started && (row == RW'(FRAME_HEIGHT - 1)) &&
                                  (col == XW'(FRAME_WIDTH))))
                                sync_error <= 1'b1;
                            frame_done   <= 1'b1;
                            frame_active <= 1'b0;
                            count        <= '0;
                            state        <= S_DONE;
                        end else if (!word[16]) begin
                            if (px_store) begin
                                col   <= col + 1'b1;
                                count <= count + 1'b1;
                                if (count == CW'(BURST_LEN - 1)) begin
                                    mem_cmd_valid <= 1'b1;
                                    mem_cmd_addr  <= burst_addr;
                                    state         <= S_CMD;
                                end
                            end else if (!row_err) begin
                                sync_error <= 1'b1;
                                row_err    <= 1'b1;
                            end
                        end
                    end
                end
                S_CMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        mem_wr_valid  <= 1'b1;
                        mem_wr_data   <= burst_buf[0];
                        beat          <= CW'(1);
                        state         <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat == CW'(BURST_LEN)) begin
                        mem_wr_valid <= 1'b0;
                        count        <= '0;
                        state        <= S_RECV;
                    end else begin
                        mem_wr_data <= burst_buf[beat[IW-1:0]];
                        beat        <= beat + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stream_writer.sv
// Directed bench for frame_stream_writer with a stream-level reference model and per-cycle output checks.
module tb_frame_stream_writer;

    localparam int W    = 32;
    localparam int H    = 2;
    localparam int BL   = 16;
    localparam int AW   = 21;
    localparam int BASE = 0;

    localparam logic [16:0] FS = 17'h10000;
    localparam logic [16:0] RS = 17'h10001;
    localparam logic [16:0] FE = 17'h1FFFF;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          queue_empty;
    logic [16:0]   queue_data;
    logic          queue_rd_en;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready;
    logic [AW-1:0] mem_cmd_addr;
    logic [15:0]   mem_wr_data;
    logic          mem_wr_valid;
    logic          frame_active;
    logic          frame_done;
    logic          sync_error;

    frame_stream_writer #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .BURST_LEN   (BL),
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (21'(BASE))
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .queue_empty  (queue_empty),
        .queue_data   (queue_data),
        .queue_rd_en  (queue_rd_en),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_addr (mem_cmd_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_valid (mem_wr_valid),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .sync_error   (sync_error)
    );

    always #5 clk = ~clk;

    logic [16:0] q[$];
    logic [16:0] stim[$];
    int exp_addr[$];
    int exp_data[$];
    int obs_addr[$];
    int obs_data[$];
    int lit_addr[$];

    int checks = 0;
    int errors = 0;
    int m_err, m_done;
    int n_cmd, n_err, n_done;
    bit saw_active;
    bit chk_en = 1'b0;
    int ready_hold = 0;
    bit tog_en = 1'b0;
    int wait_cnt = 0;
    int beats_left = 0;
    int cyc = 0;
    bit fire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO and memory-controller models: sample at negedge, drive just after posedge.
    initial begin
        queue_empty   = 1'b1;
        queue_data    = '0;
        mem_cmd_ready = 1'b0;
        forever begin
            @(negedge clk);
            fire = queue_rd_en;
            if (mem_cmd_valid && mem_cmd_ready) wait_cnt = 0;
            else if (mem_cmd_valid) wait_cnt++;
            @(posedge clk);
            #1;
            cyc++;
            if (fire && (q.size() > 0)) queue_data = q.pop_front();
            queue_empty   = (q.size() == 0) || (tog_en && cyc[0]);
            mem_cmd_ready = (wait_cnt >= ready_hold);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_while_empty", 32'(queue_rd_en & queue_empty), 0);
            chk("rd_during_burst", 32'(queue_rd_en & (mem_cmd_valid | mem_wr_valid)), 0);
            if (mem_cmd_valid) begin
                if (exp_addr.size() == 0) chk("cmd_unexpected", 32'(mem_cmd_valid), 0);
                else chk("cmd_addr", 32'(mem_cmd_addr), exp_addr[0]);
                if (mem_cmd_ready) begin
                    n_cmd++;
                    obs_addr.push_back(int'(mem_cmd_addr));
                    if (exp_addr.size() > 0) void'(exp_addr.pop_front());
                end
            end
            chk("wr_valid_window", 32'(mem_wr_valid), 32'(beats_left > 0));
            if (beats_left > 0) beats_left--;
            if (mem_cmd_valid && mem_cmd_ready) beats_left = BL;
            if (mem_wr_valid) begin
                obs_data.push_back(int'(mem_wr_data));
                if (exp_data.size() == 0) chk("data_unexpected", 32'(mem_wr_valid), 0);
                else chk("wr_data", 32'(mem_wr_data), exp_data.pop_front());
            end
            if (sync_error) n_err++;
            if (frame_done) begin
                n_done++;
                chk("done_before_last_write", exp_data.size(), 0);
                chk("active_in_done", 32'(frame_active), 0);
            end
            if (frame_active) saw_active = 1'b1;
        end
    end

    // Reference: walks the word list with the framing rules, no cycle timing.
    task automatic model_stream();
        bit active;
        int row, col;
        bit rerr;
        int bufq[$];
        active = 0; row = -1; col = 0; rerr = 0;
        m_err = 0; m_done = 0;
        foreach (stim[i]) begin
            if (!active) begin
                if (stim[i] == FS) begin
                    active = 1; row = -1; col = 0; rerr = 0; bufq.delete();
                end
            end else if (stim[i] == FS) begin
                m_err++; row = -1; col = 0; rerr = 0; bufq.delete();
            end else if (stim[i] == RS) begin
                if (col > 0 && col < W) m_err++;
                row++; col = 0; rerr = 0; bufq.delete();
            end else if (stim[i] == FE) begin
                if (row != H - 1 || col != W) m_err++;
                m_done++; active = 0; bufq.delete();
            end else if (stim[i][16] == 1'b0) begin
                if (row >= 0 && row < H && col < W) begin
                    bufq.push_back(int'(stim[i][15:0]));
                    col++;
                    if (bufq.size() == BL) begin
                        exp_addr.push_back((BASE + row * W + col - BL) % (1 << AW));
                        foreach (bufq[k]) exp_data.push_back(bufq[k]);
                        bufq.delete();
                    end
                end else if (!rerr) begin
                    m_err++; rerr = 1;
                end
            end
        end
    endtask

    task automatic add_px(input int n, input int base);
        for (int i = 0; i < n; i++) stim.push_back(17'(base + i));
    endtask

    task automatic clean_frame();
        stim.push_back(FS);
        stim.push_back(RS); add_px(W, 0);
        stim.push_back(RS); add_px(W, W);
        stim.push_back(FE);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"},     32'(queue_rd_en), 0);
        chk({tag, "_cmd_valid"}, 32'(mem_cmd_valid), 0);
        chk({tag, "_cmd_addr"},  32'(mem_cmd_addr), 0);
        chk({tag, "_wr_data"},   32'(mem_wr_data), 0);
        chk({tag, "_wr_valid"},  32'(mem_wr_valid), 0);
        chk({tag, "_active"},    32'(frame_active), 0);
        chk({tag, "_done"},      32'(frame_done), 0);
        chk({tag, "_sync_err"},  32'(sync_error), 0);
    endtask

    task automatic run_stream(input string tname, input int hold, input bit tog,
                              input int lit_cmds, input int lit_err);
        int t;
        n_cmd = 0; n_err = 0; n_done = 0; saw_active = 0;
        obs_addr.delete(); obs_data.delete();
        ready_hold = hold; tog_en = tog;
        model_stream();
        foreach (stim[i]) q.push_back(stim[i]);
        t = 0;
        while (n_done == 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        chk($sformatf("%s_done_count", tname), n_done, 1);
        chk($sformatf("%s_cmd_count", tname), n_cmd, lit_cmds);
        chk($sformatf("%s_sync_err_count", tname), n_err, lit_err);
        chk($sformatf("%s_sync_err_vs_model", tname), n_err, m_err);
        chk($sformatf("%s_data_left", tname), exp_data.size(), 0);
        chk($sformatf("%s_cmds_left", tname), exp_addr.size(), 0);
        chk($sformatf("%s_fifo_left", tname), q.size(), 0);
        chk($sformatf("%s_saw_active", tname), 32'(saw_active), 1);
        chk($sformatf("%s_active_after", tname), 32'(frame_active), 0);
        chk($sformatf("%s_addr_list_len", tname), obs_addr.size(), lit_addr.size());
        foreach (lit_addr[i])
            if (i < obs_addr.size())
                chk($sformatf("%s_addr%0d", tname, i), obs_addr[i], lit_addr[i]);
        stim.delete();
        tog_en = 0;
    endtask

    initial begin
        int bad;
        int t;
        reset_n = 1'b0;
        q.push_back(17'h00123);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (4) @(negedge clk);

        // Clean frame, data = pixel index.
        clean_frame();
        lit_addr = '{0, 16, 32, 48};
        run_stream("clean", 0, 0, 4, 0);
        bad = 0;
        foreach (obs_data[i]) if (obs_data[i] != i) bad++;
        chk("clean_data_len", obs_data.size(), 64);
        chk("clean_data_is_index", bad, 0);

        // Command backpressure.
        clean_frame();
        run_stream("stall", 10, 0, 4, 0);

        // FIFO empty toggling.
        clean_frame();
        run_stream("toggle", 0, 1, 4, 0);

        // Short row: one burst, 4 pixels dropped.
        stim.push_back(FS);
        stim.push_back(RS); add_px(20, 0);
        stim.push_back(RS); add_px(W, 100);
        stim.push_back(FE);
        lit_addr = '{0, 32, 48};
        run_stream("short_row", 0, 0, 3, 1);

        // Long row: 8 pixels discarded, one error.
        stim.push_back(FS);
        stim.push_back(RS); add_px(40, 0);
        stim.push_back(RS); add_px(W, 200);
        stim.push_back(FE);
        lit_addr = '{0, 16, 32, 48};
        run_stream("long_row", 0, 0, 4, 1);

        // Frame restart mid-frame.
        stim.push_back(FS);
        stim.push_back(RS); add_px(10, 500);
        clean_frame();
        run_stream("restart", 0, 0, 4, 1);

        // Reset during a data burst.
        clean_frame();
        model_stream();
        foreach (stim[i]) q.push_back(stim[i]);
        stim.delete();
        t = 0;
        while (!mem_wr_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("reset_test_reached_data", 32'(mem_wr_valid), 1);
        repeat (3) @(negedge clk);
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) @(negedge clk);
        q.delete(); exp_addr.delete(); exp_data.delete();
        beats_left = 0; wait_cnt = 0;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (3) @(negedge clk);

        clean_frame();
        run_stream("after_reset", 0, 0, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
